// File: rtl/uart_buffered_if.sv
// Peripheral bus bundle for the buffered UART: request held until a one-cycle ack.
// Reads return data during the ack cycle; writes take effect at the end of it.
interface uart_buffered_if;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_addr;
  logic [31:0] s_rdata;
  logic [31:0] s_wdata;
  logic [3:0]  s_wstrb;

  modport master (output s_valid, s_addr, s_wdata, s_wstrb, input s_ready, s_rdata);
  modport slave  (input s_valid, s_addr, s_wdata, s_wstrb, output s_ready, s_rdata);
endinterface

// File: rtl/uart_buffered.sv
// Memory-mapped UART with TX/RX FIFOs, build-time parity, runtime divisor, sticky errors and irq.
// Bus ack one cycle after request; a full FIFO drops the new byte and sets an overflow flag.
module fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wp, rp;
  logic         do_push, do_pop;

  assign empty   = (wp == rp);
  assign full    = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rp[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_push) wp <= wp + (AW+1)'(1);
      if (do_pop)  rp <= rp + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wp[AW-1:0]] <= din;
  end
endmodule

module uart_buffered #(
  parameter int CLK_FREQ  = 100000000,
  parameter int BAUD_RATE = 115200,
  parameter int TX_DEPTH  = 16,
  parameter int RX_DEPTH  = 16,
  parameter int PARITY    = 0
) (
  input  logic             clk,
  input  logic             resetn,
  uart_buffered_if.slave   bus,
  input  logic             uart_rxd,
  output logic             uart_txd,
  output logic             irq
);
  localparam logic [15:0] DIV_RST = 16'(CLK_FREQ / BAUD_RATE - 1);
  localparam bit HAS_PAR = (PARITY != 0);
  localparam bit ODD     = (PARITY == 2);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_PAR   = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;

  logic [15:0] div;
  logic [1:0]  ctrl;
  logic        rxovr, frerr, parerr, txovf;
  logic        rd_pop;

  logic        req, ack, is_wr;
  logic [1:0]  sel;
  logic [8:0]  status;
  logic [15:0] div_new;
  logic        unused_ok;

  logic        tx_push, tx_pop, tx_full, tx_empty, tx_busy;
  logic [7:0]  tx_dout;
  logic        rx_push, rx_pop, rx_full, rx_empty;
  logic [7:0]  rx_dout;

  logic [2:0]  tx_state;
  logic [15:0] tx_cnt, tx_div_q;
  logic [2:0]  tx_bit;
  logic [7:0]  tx_sh;
  logic        tx_par, tx_end;

  logic        rx_s1, rx_s2, rx_s3;
  logic [2:0]  rx_state;
  logic [15:0] rx_cnt, rx_div_q, rx_half;
  logic [2:0]  rx_bit;
  logic [7:0]  rx_sh;
  logic        rx_par_bad, rx_end, rx_stop_samp;
  logic        frerr_set, parerr_set, rxovr_set, txovf_set;

  assign req   = bus.s_valid & ~bus.s_ready;
  assign ack   = bus.s_valid & bus.s_ready;
  assign is_wr = |bus.s_wstrb;
  assign sel   = bus.s_addr[3:2];
  assign unused_ok = ^{bus.s_addr[31:4], bus.s_addr[1:0], bus.s_wdata[31:16]};

  assign tx_busy = (tx_state != S_IDLE);
  assign status  = {txovf, tx_busy, parerr, frerr, rxovr, rx_full, ~rx_empty, tx_empty, tx_full};
  assign div_new = {bus.s_wstrb[1] ? bus.s_wdata[15:8] : div[15:8],
                    bus.s_wstrb[0] ? bus.s_wdata[7:0]  : div[7:0]};

  assign tx_push   = ack & is_wr & (sel == 2'd0) & bus.s_wstrb[0];
  assign rx_pop    = ack & rd_pop;
  assign txovf_set = tx_push & tx_full & ~tx_pop;

  fifo #(.W(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk(clk), .resetn(resetn), .push(tx_push), .din(bus.s_wdata[7:0]),
    .pop(tx_pop), .dout(tx_dout), .full(tx_full), .empty(tx_empty)
  );

  fifo #(.W(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk(clk), .resetn(resetn), .push(rx_push), .din(rx_sh),
    .pop(rx_pop), .dout(rx_dout), .full(rx_full), .empty(rx_empty)
  );

  // Read data is captured in the request cycle; the pop decision travels with it so
  // a byte arriving during the ack cycle is never consumed unseen.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      bus.s_ready <= 1'b0;
      bus.s_rdata <= '0;
      rd_pop      <= 1'b0;
    end else begin
      bus.s_ready <= req;
      bus.s_rdata <= '0;
      rd_pop      <= 1'b0;
      if (req && !is_wr) begin
        case (sel)
          2'd0: if (!rx_empty) begin
            bus.s_rdata <= {23'b0, 1'b1, rx_dout};
            rd_pop      <= 1'b1;
          end
          2'd1:    bus.s_rdata <= {23'b0, status};
          2'd2:    bus.s_rdata <= {16'b0, div};
          default: bus.s_rdata <= {30'b0, ctrl};
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      div    <= DIV_RST;
      ctrl   <= 2'b00;
      rxovr  <= 1'b0;
      frerr  <= 1'b0;
      parerr <= 1'b0;
      txovf  <= 1'b0;
    end else begin
      if (ack && is_wr) begin
        if (sel == 2'd2 && |bus.s_wstrb[1:0])
          div <= (div_new < 16'd7) ? 16'd7 : div_new;
        if (sel == 2'd3 && bus.s_wstrb[0])
          ctrl <= bus.s_wdata[1:0];
        if (sel == 2'd1 && bus.s_wstrb[0]) begin
          if (bus.s_wdata[4]) rxovr  <= 1'b0;
          if (bus.s_wdata[5]) frerr  <= 1'b0;
          if (bus.s_wdata[6]) parerr <= 1'b0;
        end
        if (sel == 2'd1 && bus.s_wstrb[1] && bus.s_wdata[8]) txovf <= 1'b0;
      end
      if (rxovr_set)  rxovr  <= 1'b1;
      if (frerr_set)  frerr  <= 1'b1;
      if (parerr_set) parerr <= 1'b1;
      if (txovf_set)  txovf  <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) irq <= 1'b0;
    else         irq <= (ctrl[0] & ~rx_empty) | (ctrl[1] & tx_empty & ~tx_busy);
  end

  assign tx_end = (tx_cnt == tx_div_q);
  assign tx_pop = ~tx_empty & ((tx_state == S_IDLE) | ((tx_state == S_STOP) & tx_end));

  always_ff @(posedge clk) begin
    if (!resetn) begin
      tx_state <= S_IDLE;
      uart_txd <= 1'b1;
      tx_cnt   <= '0;
      tx_div_q <= '0;
      tx_bit   <= '0;
      tx_sh    <= '0;
      tx_par   <= 1'b0;
    end else begin
      case (tx_state)
        S_IDLE: if (tx_pop) begin
          tx_state <= S_START;
          uart_txd <= 1'b0;
          tx_cnt   <= '0;
          tx_sh    <= tx_dout;
          tx_par   <= (^tx_dout) ^ ODD;
          tx_div_q <= div;
        end
        S_START: if (tx_end) begin
          tx_cnt   <= '0;
          tx_bit   <= '0;
          tx_state <= S_DATA;
          uart_txd <= tx_sh[0];
          tx_sh    <= {1'b0, tx_sh[7:1]};
        end else tx_cnt <= tx_cnt + 16'd1;
        S_DATA: if (tx_end) begin
          tx_cnt <= '0;
          if (tx_bit == 3'd7) begin
            tx_state <= HAS_PAR ? S_PAR : S_STOP;
            uart_txd <= HAS_PAR ? tx_par : 1'b1;
          end else begin
            tx_bit   <= tx_bit + 3'd1;
            uart_txd <= tx_sh[0];
            tx_sh    <= {1'b0, tx_sh[7:1]};
          end
        end else tx_cnt <= tx_cnt + 16'd1;
        S_PAR: if (tx_end) begin
          tx_cnt   <= '0;
          tx_state <= S_STOP;
          uart_txd <= 1'b1;
        end else tx_cnt <= tx_cnt + 16'd1;
        S_STOP: if (tx_end) begin
          tx_cnt <= '0;
          // Next byte starts straight out of the stop bit; the divisor is resampled here.
          if (tx_pop) begin
            tx_state <= S_START;
            uart_txd <= 1'b0;
            tx_sh    <= tx_dout;
            tx_par   <= (^tx_dout) ^ ODD;
            tx_div_q <= div;
          end else tx_state <= S_IDLE;
        end else tx_cnt <= tx_cnt + 16'd1;
        default: begin
          tx_state <= S_IDLE;
          uart_txd <= 1'b1;
        end
      endcase
    end
  end

  assign rx_half      = {1'b0, rx_div_q[15:1]} + {15'b0, rx_div_q[0]};
  assign rx_end       = (rx_cnt == rx_div_q);
  assign rx_stop_samp = (rx_state == S_STOP) & rx_end;
  assign frerr_set    = rx_stop_samp & ~rx_s2;
  assign parerr_set   = rx_stop_samp & rx_s2 & rx_par_bad;
  assign rx_push      = rx_stop_samp & rx_s2 & ~rx_par_bad;
  assign rxovr_set    = rx_push & rx_full & ~rx_pop;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rx_s1      <= 1'b1;
      rx_s2      <= 1'b1;
      rx_s3      <= 1'b1;
      rx_state   <= S_IDLE;
      rx_cnt     <= '0;
      rx_div_q   <= '0;
      rx_bit     <= '0;
      rx_sh      <= '0;
      rx_par_bad <= 1'b0;
    end else begin
      rx_s1 <= uart_rxd;
      rx_s2 <= rx_s1;
      rx_s3 <= rx_s2;
      case (rx_state)
        S_IDLE: if (rx_s3 && !rx_s2) begin
          rx_state   <= S_START;
          rx_cnt     <= '0;
          rx_div_q   <= div;
          rx_par_bad <= 1'b0;
        end
        S_START: if (rx_cnt == rx_half) begin
          rx_cnt   <= '0;
          rx_bit   <= '0;
          rx_state <= rx_s2 ? S_IDLE : S_DATA;
        end else rx_cnt <= rx_cnt + 16'd1;
        S_DATA: if (rx_end) begin
          rx_cnt <= '0;
          rx_sh  <= {rx_s2, rx_sh[7:1]};
          rx_bit <= rx_bit + 3'd1;
          if (rx_bit == 3'd7) rx_state <= HAS_PAR ? S_PAR : S_STOP;
        end else rx_cnt <= rx_cnt + 16'd1;
        S_PAR: if (rx_end) begin
          rx_cnt     <= '0;
          rx_par_bad <= rx_s2 != ((^rx_sh) ^ ODD);
          rx_state   <= S_STOP;
        end else rx_cnt <= rx_cnt + 16'd1;
        S_STOP: if (rx_end) rx_state <= S_IDLE;
                else        rx_cnt   <= rx_cnt + 16'd1;
        default: rx_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_buffered.sv
// Scoreboard bench: bus reads and TX frames are queued as expectations, monitors compare.
module tb_uart_buffered;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic resetn;
  logic txd, irq, rxd, rxd_drv, loop;
  logic ptxd, pirq, prxd;
  bit   mon_en;
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  logic [31:0] rd_q[$];
  string       rd_nm[$];
  logic [7:0]  tx_q[$];
  int          tx_start[$];

  uart_buffered_if bus();
  uart_buffered_if pbus();

  assign rxd = loop ? txd : rxd_drv;

  uart_buffered #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .TX_DEPTH(4), .RX_DEPTH(4), .PARITY(0))
    u_dut (.clk(clk), .resetn(resetn), .bus(bus), .uart_rxd(rxd), .uart_txd(txd), .irq(irq));

  uart_buffered #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .TX_DEPTH(4), .RX_DEPTH(4), .PARITY(1))
    u_par (.clk(clk), .resetn(resetn), .bus(pbus), .uart_rxd(prxd), .uart_txd(ptxd), .irq(pirq));

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic mon_rd(input logic [31:0] d);
    string nm;
    logic [31:0] e;
    if (rd_q.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL unexpected_read: got 0x%0h, want none", d);
    end else begin
      nm = rd_nm.pop_front();
      e  = rd_q.pop_front();
      check(nm, d, e);
    end
  endtask

  always @(negedge clk) begin
    if (bus.s_valid && bus.s_ready && bus.s_wstrb == 4'h0)   mon_rd(bus.s_rdata);
    if (pbus.s_valid && pbus.s_ready && pbus.s_wstrb == 4'h0) mon_rd(pbus.s_rdata);
  end

  // TX frame monitor: samples mid-bit, 10 clocks per bit.
  initial begin
    logic prev;
    logic [7:0] b;
    logic stp;
    prev = 1'b1;
    b = '0;
    forever begin
      @(negedge clk);
      if (mon_en && prev && !txd) begin
        tx_start.push_back(cyc);
        repeat (4) @(negedge clk);
        check("tx_start_bit", {31'b0, txd}, 32'd0);
        for (int k = 0; k < 8; k++) begin
          repeat (10) @(negedge clk);
          b[k] = txd;
        end
        repeat (10) @(negedge clk);
        stp = txd;
        if (tx_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_tx_frame: got 0x%0h, want none", b);
        end else check("tx_byte", {24'b0, b}, {24'b0, tx_q.pop_front()});
        check("tx_stop", {31'b0, stp}, 32'd1);
      end
      prev = txd;
    end
  end

  task automatic xfer(input bit p, input logic [3:0] addr, input logic [3:0] strb,
                      input logic [31:0] wd, input string nm, input logic [31:0] exp);
    bit got;
    got = 1'b0;
    if (strb == 4'h0) begin
      rd_q.push_back(exp);
      rd_nm.push_back(nm);
    end
    @(posedge clk); #1;
    if (p) begin
      pbus.s_valid = 1'b1; pbus.s_addr = {28'b0, addr}; pbus.s_wstrb = strb; pbus.s_wdata = wd;
    end else begin
      bus.s_valid = 1'b1; bus.s_addr = {28'b0, addr}; bus.s_wstrb = strb; bus.s_wdata = wd;
    end
    for (int i = 0; i < 8 && !got; i++) begin
      @(posedge clk); #1;
      got = p ? pbus.s_ready : bus.s_ready;
    end
    if (!got) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: no s_ready within 8 cycles", nm);
      if (strb == 4'h0) begin
        void'(rd_q.pop_back());
        void'(rd_nm.pop_back());
      end
    end
    @(posedge clk); #1;
    bus.s_valid = 1'b0;  bus.s_wstrb = 4'h0;
    pbus.s_valid = 1'b0; pbus.s_wstrb = 4'h0;
  endtask

  task automatic rd(input bit p, input logic [3:0] addr, input string nm, input logic [31:0] exp);
    xfer(p, addr, 4'h0, 32'h0, nm, exp);
  endtask

  task automatic wr(input bit p, input logic [3:0] addr, input logic [31:0] wd);
    xfer(p, addr, 4'hF, wd, "write", 32'h0);
  endtask

  task automatic send_tx(input logic [7:0] b, input bit expect_frame);
    if (expect_frame) tx_q.push_back(b);
    wr(1'b0, 4'h0, {24'b0, b});
  endtask

  task automatic wait_tx(input int budget);
    int n;
    n = 0;
    while (tx_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (tx_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL tx_timeout: got %0d frames pending, want 0", tx_q.size());
      tx_q.delete();
    end
    repeat (20) @(posedge clk);
    #1;
  endtask

  task automatic setl(input bit p, input logic v);
    if (p) prxd = v;
    else   rxd_drv = v;
  endtask

  task automatic bit_time();
    repeat (10) @(posedge clk);
    #1;
  endtask

  // par < 0 means no parity bit on the wire.
  task automatic ser(input bit p, input logic [7:0] b, input int par, input logic stop);
    @(posedge clk); #1;
    setl(p, 1'b0); bit_time();
    for (int i = 0; i < 8; i++) begin
      setl(p, b[i]); bit_time();
    end
    if (par >= 0) begin
      setl(p, (par != 0)); bit_time();
    end
    setl(p, stop); bit_time();
    setl(p, 1'b1); bit_time();
  endtask

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: got no finish, want finish within 60000 cycles");
    $fatal(1);
  end

  initial begin
    resetn = 1'b0; rxd_drv = 1'b1; prxd = 1'b1; loop = 1'b0; mon_en = 1'b1;
    bus.s_valid = 1'b0;  bus.s_addr = '0;  bus.s_wdata = '0;  bus.s_wstrb = '0;
    pbus.s_valid = 1'b0; pbus.s_addr = '0; pbus.s_wdata = '0; pbus.s_wstrb = '0;
    repeat (5) @(posedge clk);
    #1;
    check("rst_s_ready", {31'b0, bus.s_ready}, 32'd0);
    check("rst_s_rdata", bus.s_rdata, 32'd0);
    check("rst_txd", {31'b0, txd}, 32'd1);
    check("rst_irq", {31'b0, irq}, 32'd0);
    check("rst_par_txd", {31'b0, ptxd}, 32'd1);
    check("rst_par_irq", {31'b0, pirq}, 32'd0);
    resetn = 1'b1;

    rd(0, 4'h4, "rst_status", 32'h002);
    rd(0, 4'h8, "rst_div", 32'd9);
    rd(0, 4'hC, "rst_ctrl", 32'h0);
    rd(0, 4'h0, "rst_data_empty", 32'h0);

    // Two bytes back to back: 100 clocks between start edges.
    tx_start.delete();
    send_tx(8'h55, 1'b1);
    send_tx(8'hA3, 1'b1);
    wait_tx(400);
    if (tx_start.size() >= 2) check("b2b_gap", 32'(tx_start[1] - tx_start[0]), 32'd100);
    else check("b2b_frames", 32'(tx_start.size()), 32'd2);
    rd(0, 4'h4, "tx_done_status", 32'h002);

    // TX overflow: one in flight, four queued, sixth dropped.
    for (int i = 0; i < 6; i++) send_tx(8'h10 + 8'(i), i < 5);
    rd(0, 4'h4, "txovf_status", 32'h181);
    wr(0, 4'h4, 32'h100);
    rd(0, 4'h4, "txovf_cleared", 32'h081);
    wait_tx(700);
    rd(0, 4'h4, "txovf_drained", 32'h002);

    wr(0, 4'hC, 32'h2);
    repeat (3) @(posedge clk);
    #1 check("irq_tx_idle", {31'b0, irq}, 32'd1);
    wr(0, 4'hC, 32'h0);
    repeat (3) @(posedge clk);
    #1 check("irq_off", {31'b0, irq}, 32'd0);

    // Loopback of three bytes with rx interrupt enabled.
    loop = 1'b1;
    wr(0, 4'hC, 32'h1);
    send_tx(8'h11, 1'b1);
    send_tx(8'h22, 1'b1);
    send_tx(8'h33, 1'b1);
    wait_tx(500);
    check("irq_rx", {31'b0, irq}, 32'd1);
    rd(0, 4'hC, "ctrl_rx_ie", 32'h1);
    rd(0, 4'h4, "loop_status", 32'h006);
    rd(0, 4'h0, "loop_b0", 32'h111);
    rd(0, 4'h0, "loop_b1", 32'h122);
    rd(0, 4'h0, "loop_b2", 32'h133);
    rd(0, 4'h0, "loop_empty", 32'h000);
    #1 check("irq_rx_cleared", {31'b0, irq}, 32'd0);
    rd(0, 4'h4, "loop_status_after", 32'h002);
    wr(0, 4'hC, 32'h0);

    // RX overflow: RX_DEPTH+1 bytes with no reads.
    for (int i = 1; i <= 5; i++) send_tx(8'(i), 1'b1);
    wait_tx(800);
    rd(0, 4'h4, "rxovr_status", 32'h01E);
    wr(0, 4'h4, 32'h010);
    rd(0, 4'h4, "rxovr_cleared", 32'h00E);
    for (int i = 1; i <= 4; i++) rd(0, 4'h0, "rxovr_data", 32'h100 + 32'(i));
    rd(0, 4'h0, "rxovr_empty", 32'h000);
    loop = 1'b0;

    // Framing error, then a clean frame to show the receiver recovers.
    ser(0, 8'h5A, -1, 1'b0);
    rd(0, 4'h4, "frerr_status", 32'h022);
    rd(0, 4'h0, "frerr_no_push", 32'h000);
    wr(0, 4'h4, 32'h020);
    rd(0, 4'h4, "frerr_cleared", 32'h002);
    ser(0, 8'h3C, -1, 1'b1);
    rd(0, 4'h0, "after_frerr", 32'h13C);

    // Three-clock glitch must not start a frame.
    @(posedge clk); #1 rxd_drv = 1'b0;
    repeat (3) @(posedge clk);
    #1 rxd_drv = 1'b1;
    repeat (150) @(posedge clk);
    rd(0, 4'h4, "glitch_status", 32'h002);
    rd(0, 4'h0, "glitch_data", 32'h000);

    wr(0, 4'h8, 32'd3);
    rd(0, 4'h8, "div_clamp", 32'd7);
    wr(0, 4'h8, 32'd19);
    rd(0, 4'h8, "div_set", 32'd19);
    wr(0, 4'h8, 32'd9);

    // Even parity build: 0x5A has even weight so its parity bit is 0.
    ser(1, 8'h5A, 1, 1'b1);
    rd(1, 4'h4, "parerr_status", 32'h042);
    rd(1, 4'h0, "parerr_no_push", 32'h000);
    wr(1, 4'h4, 32'h040);
    ser(1, 8'h5A, 0, 1'b1);
    ser(1, 8'h07, 1, 1'b1);
    rd(1, 4'h0, "par_ok0", 32'h15A);
    rd(1, 4'h0, "par_ok1", 32'h107);
    rd(1, 4'h4, "par_status", 32'h002);

    // Reset in the middle of a frame returns txd high on the next cycle.
    mon_en = 1'b0;
    wr(0, 4'h0, 32'h00);
    repeat (30) @(posedge clk);
    #1 check("midframe_txd_low", {31'b0, txd}, 32'd0);
    resetn = 1'b0;
    @(posedge clk);
    #1 check("midframe_reset_txd", {31'b0, txd}, 32'd1);
    resetn = 1'b1;
    rd(0, 4'h4, "post_reset_status", 32'h002);
    rd(0, 4'h8, "post_reset_div", 32'd9);

    check("rd_queue_drained", 32'(rd_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
